// File: rtl/conv_window_feeder_pkg.sv
// Shared definitions for the convolution window feeder.
// Holds the default geometry, the FSM state encoding and the helpers that
// locate an operand byte inside the flattened A/B buses (0-based indices).
package conv_window_feeder_pkg;

  localparam int unsigned CW_DW   = 8;
  localparam int unsigned CW_IMG  = 4;
  localparam int unsigned CW_K    = 3;
  localparam int unsigned CW_OUT  = CW_IMG - CW_K + 1;
  localparam int unsigned CW_NTAP = CW_K * CW_K;
  localparam int unsigned CW_NWIN = CW_OUT * CW_OUT;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // LSB of A(r,c) in a_flat, r/c 0-based.
  function automatic int unsigned a_lsb(input int unsigned r, input int unsigned c,
                                        input int unsigned img, input int unsigned dw);
    return dw * (img * r + c);
  endfunction

  // LSB of B(i,j) in b_flat, i/j 0-based.
  function automatic int unsigned b_lsb(input int unsigned i, input int unsigned j,
                                        input int unsigned k, input int unsigned dw);
    return dw * (k * i + j);
  endfunction

endpackage

// File: rtl/conv_window_feeder_counter.sv
// Nested window/tap counters for the convolution window feeder.
// Windows are the outer row-major loop, taps the inner row-major loop.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   i_adv         advance one beat (handshake)
//   o_win_r/c     window row/column (0..OUT-1)
//   o_tap_r/c     tap row/column (0..K-1)
//   o_first       tap (0,0) of the current window
//   o_last        tap (K-1,K-1) of the current window
//   o_final       last tap of the last window
module conv_window_counter #(
  parameter int unsigned OUT = 2,
  parameter int unsigned K   = 3,
  parameter int unsigned WW  = (OUT > 1) ? $clog2(OUT) : 1,
  parameter int unsigned TW  = (K > 1) ? $clog2(K) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_adv,
  output logic [WW-1:0] o_win_r,
  output logic [WW-1:0] o_win_c,
  output logic [TW-1:0] o_tap_r,
  output logic [TW-1:0] o_tap_c,
  output logic          o_first,
  output logic          o_last,
  output logic          o_final
);

  logic [WW-1:0] r_win_r, r_win_c;
  logic [TW-1:0] r_tap_r, r_tap_c;
  logic          w_tap_c_end, w_tap_r_end, w_win_c_end, w_win_r_end;

  always_comb begin
    w_tap_c_end = (r_tap_c == TW'(K - 1));
    w_tap_r_end = (r_tap_r == TW'(K - 1));
    w_win_c_end = (r_win_c == WW'(OUT - 1));
    w_win_r_end = (r_win_r == WW'(OUT - 1));
  end

  // Each counter wraps into the next outer one; the final beat returns all
  // four to zero so a following run starts clean.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_win_r <= '0;
      r_win_c <= '0;
      r_tap_r <= '0;
      r_tap_c <= '0;
    end else if (i_adv) begin
      if (!w_tap_c_end) begin
        r_tap_c <= r_tap_c + 1'b1;
      end else begin
        r_tap_c <= '0;
        if (!w_tap_r_end) begin
          r_tap_r <= r_tap_r + 1'b1;
        end else begin
          r_tap_r <= '0;
          if (!w_win_c_end) begin
            r_win_c <= r_win_c + 1'b1;
          end else begin
            r_win_c <= '0;
            if (!w_win_r_end) r_win_r <= r_win_r + 1'b1;
            else              r_win_r <= '0;
          end
        end
      end
    end
  end

  always_comb begin
    o_win_r = r_win_r;
    o_win_c = r_win_c;
    o_tap_r = r_tap_r;
    o_tap_c = r_tap_c;
    o_first = (r_tap_r == '0) && (r_tap_c == '0);
    o_last  = w_tap_r_end && w_tap_c_end;
    o_final = o_last && w_win_r_end && w_win_c_end;
  end

endmodule

// File: rtl/conv_window_feeder.sv
// Convolution window feeder.
// Snapshots the 4x4 A matrix and 3x3 B filter on an accepted start, then
// streams the (a, b) operand pair of every tap of every 3x3 window as a
// valid/ready stream, followed by a one-cycle done pulse.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             run request, accepted only in IDLE
//   a_flat, b_flat    flattened A and B operand banks
//   out_valid/ready   stream handshake
//   out_a, out_b      operand pair of the current beat
//   out_first/last    first/last tap of the current window
//   out_win           window index, row-major
//   busy              run in progress (STREAM or DONE)
//   done              one-cycle completion pulse
module conv_window_feeder
  import conv_window_feeder_pkg::*;
#(
  parameter int unsigned DW  = CW_DW,
  parameter int unsigned IMG = CW_IMG,
  parameter int unsigned K   = CW_K
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [IMG*IMG*DW-1:0] a_flat,
  input  logic [K*K*DW-1:0]     b_flat,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DW-1:0]         out_a,
  output logic [DW-1:0]         out_b,
  output logic                  out_first,
  output logic                  out_last,
  output logic [1:0]            out_win,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned OUT = IMG - K + 1;
  localparam int unsigned WW  = (OUT > 1) ? $clog2(OUT) : 1;
  localparam int unsigned TW  = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned AW  = (IMG > 1) ? $clog2(IMG) : 1;

  state_t                r_state;
  logic                  r_valid;
  logic                  r_busy;
  logic                  r_done;
  logic [IMG*IMG*DW-1:0] r_a_snap;
  logic [K*K*DW-1:0]     r_b_snap;

  logic          w_adv;
  logic [WW-1:0] w_win_r, w_win_c;
  logic [TW-1:0] w_tap_r, w_tap_c;
  logic          w_first, w_last, w_final;
  logic [AW-1:0] w_ar, w_ac;
  logic [DW-1:0] w_a_sel, w_b_sel;
  logic [DW-1:0] w_a_mat [IMG][IMG];
  logic [DW-1:0] w_b_mat [K][K];

  assign w_adv = r_valid & out_ready;

  conv_window_counter #(
    .OUT (OUT),
    .K   (K),
    .WW  (WW),
    .TW  (TW)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_adv   (w_adv),
    .o_win_r (w_win_r),
    .o_win_c (w_win_c),
    .o_tap_r (w_tap_r),
    .o_tap_c (w_tap_c),
    .o_first (w_first),
    .o_last  (w_last),
    .o_final (w_final)
  );

  for (genvar r = 0; r < IMG; r++) begin : g_a_row
    for (genvar c = 0; c < IMG; c++) begin : g_a_col
      assign w_a_mat[r][c] = r_a_snap[a_lsb(r, c, IMG, DW) +: DW];
    end
  end

  for (genvar i = 0; i < K; i++) begin : g_b_row
    for (genvar j = 0; j < K; j++) begin : g_b_col
      assign w_b_mat[i][j] = r_b_snap[b_lsb(i, j, K, DW) +: DW];
    end
  end

  always_comb begin
    w_ar    = AW'(w_win_r) + AW'(w_tap_r);
    w_ac    = AW'(w_win_c) + AW'(w_tap_c);
    w_a_sel = w_a_mat[w_ar][w_ac];
    w_b_sel = w_b_mat[w_tap_r][w_tap_c];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_a_snap <= '0;
      r_b_snap <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a_snap <= a_flat;
            r_b_snap <= b_flat;
            r_state  <= ST_STREAM;
            r_valid  <= 1'b1;
            r_busy   <= 1'b1;
          end
        end
        ST_STREAM: begin
          if (w_adv && w_final) begin
            r_state <= ST_DONE;
            r_valid <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // Beat fields are forced to zero outside STREAM so idle outputs match the
  // reset values even though the counters sit at tap (0,0).
  always_comb begin
    out_valid = r_valid;
    out_a     = r_valid ? w_a_sel : '0;
    out_b     = r_valid ? w_b_sel : '0;
    out_first = r_valid & w_first;
    out_last  = r_valid & w_last;
    out_win   = r_valid ? 2'(32'(OUT) * 32'(w_win_r) + 32'(w_win_c)) : '0;
    busy      = r_busy;
    done      = r_done;
  end

endmodule

// File: tb/tb_conv_window_feeder.sv
module tb_conv_window_feeder;

  logic         clk = 1'b0;
  logic         rst, start, out_ready;
  logic [127:0] a_flat;
  logic [71:0]  b_flat;
  logic         out_valid, out_first, out_last, busy, done;
  logic [7:0]   out_a, out_b;
  logic [1:0]   out_win;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;
  int A [4][4];
  int B [3][3];
  int wsum [4];

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) n_done = n_done + 1;

  conv_window_feeder dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a_flat    (a_flat),
    .b_flat    (b_flat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_first (out_first),
    .out_last  (out_last),
    .out_win   (out_win),
    .busy      (busy),
    .done      (done)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_default;
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) A[r][c] = 4 * r + c + 1;
    for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) B[i][j] = 3 * i + j + 1;
  endtask

  task automatic set_random;
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) A[r][c] = int'($urandom_range(0, 255));
    for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) B[i][j] = int'($urandom_range(0, 255));
  endtask

  task automatic pack;
    logic [31:0] v;
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) begin
      v = A[r][c];
      a_flat[8*(4*r+c) +: 8] = v[7:0];
    end
    for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) begin
      v = B[i][j];
      b_flat[8*(3*i+j) +: 8] = v[7:0];
    end
  endtask

  // Reference: beat n is tap n%9 of window n/9, both enumerated row-major.
  function automatic int exp_a(input int n);
    int w, t;
    w = n / 9;
    t = n % 9;
    return A[w / 2 + t / 3][w % 2 + t % 3];
  endfunction

  function automatic int exp_b(input int n);
    return B[(n % 9) / 3][(n % 9) % 3];
  endfunction

  function automatic int conv(input int w);
    int s = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        s += A[w / 2 + i][w % 2 + j] * B[i][j];
    return s;
  endfunction

  task automatic check_beat(input int n);
    chk($sformatf("valid[%0d]", n), out_valid, 1);
    chk($sformatf("busy[%0d]", n), busy, 1);
    chk($sformatf("done[%0d]", n), done, 0);
    chk($sformatf("a[%0d]", n), out_a, exp_a(n));
    chk($sformatf("b[%0d]", n), out_b, exp_b(n));
    chk($sformatf("first[%0d]", n), out_first, (n % 9) == 0);
    chk($sformatf("last[%0d]", n), out_last, (n % 9) == 8);
    chk($sformatf("win[%0d]", n), out_win, n / 9);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_a"}, out_a, 0);
    chk({tag, "_b"}, out_b, 0);
    chk({tag, "_first"}, out_first, 0);
    chk({tag, "_last"}, out_last, 0);
    chk({tag, "_win"}, out_win, 0);
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Consumes one run starting at its beat-0 cycle; ends in the DONE cycle.
  task automatic run_beats(input int stall_at, input int stall_len, input bit rnd,
                           input int restart_at, output int ncyc);
    int  beat;
    int  stalled;
    bit  r;
    beat    = 0;
    stalled = 0;
    ncyc    = 0;
    for (int w = 0; w < 4; w++) wsum[w] = 0;
    while (beat < 36 && ncyc < 400) begin
      check_beat(beat);
      if (beat == restart_at) begin
        a_flat = '1;
        start  = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (rnd) r = 1'($urandom_range(0, 1));
      else     r = !(beat == stall_at && stalled < stall_len);
      if (!r) stalled++;
      out_ready = r;
      if (r) begin
        wsum[beat / 9] += out_a * out_b;
        beat++;
      end
      tick();
      ncyc++;
    end
    start     = 1'b0;
    out_ready = 1'b1;
    chk("beats_seen", beat, 36);
    chk("done_pulse", done, 1);
    chk("done_valid", out_valid, 0);
    chk("done_busy", busy, 1);
  endtask

  initial begin
    int nc, d0;

    rst       = 1'b1;
    start     = 1'b0;
    out_ready = 1'b0;
    set_default();
    pack();
    tick();
    tick();
    check_idle("reset");
    rst = 1'b0;
    tick();
    check_idle("idle");

    // Ordering, full throughput.
    out_ready = 1'b1;
    d0 = n_done;
    pulse_start();
    run_beats(-1, 0, 1'b0, -1, nc);
    chk("t1_stream_cycles", nc, 36);
    for (int w = 0; w < 4; w++) chk($sformatf("t1_sum[%0d]", w), wsum[w], conv(w));
    tick();
    check_idle("t1_after");
    chk("t1_done_count", n_done - d0, 1);

    // Backpressure on beat 4.
    pulse_start();
    run_beats(4, 5, 1'b0, -1, nc);
    chk("t2_stream_cycles", nc, 41);
    for (int w = 0; w < 4; w++) chk($sformatf("t2_sum[%0d]", w), wsum[w], conv(w));
    tick();

    // Snapshot isolation and ignored restart.
    d0 = n_done;
    pulse_start();
    run_beats(-1, 0, 1'b0, 10, nc);
    for (int w = 0; w < 4; w++) chk($sformatf("t3_sum[%0d]", w), wsum[w], conv(w));
    tick();
    tick();
    check_idle("t3_after");
    chk("t3_done_count", n_done - d0, 1);
    pack();

    // Reset mid-run.
    pulse_start();
    for (int n = 0; n < 20; n++) begin
      check_beat(n);
      tick();
    end
    check_beat(20);
    d0  = n_done;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("t4_reset");
    tick();
    tick();
    tick();
    chk("t4_no_done", n_done - d0, 0);
    pulse_start();
    run_beats(-1, 0, 1'b0, -1, nc);
    tick();

    // Random ready, random data, three runs.
    d0 = n_done;
    for (int run = 0; run < 3; run++) begin
      set_random();
      pack();
      pulse_start();
      run_beats(-1, 0, 1'b1, -1, nc);
      for (int w = 0; w < 4; w++) chk($sformatf("t5_run%0d_sum[%0d]", run, w), wsum[w], conv(w));
      tick();
    end
    chk("t5_done_count", n_done - d0, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
